// File: rtl/combi_unit_if.sv
// Signal bundle for combi_unit: operand/control inputs and the combinational,
// pipelined and coverage outputs.
interface combi_unit_if;
    logic        in_valid;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        clr_seen;
    logic        x;
    logic        y;
    logic        x_q;
    logic        y_q;
    logic        out_valid;
    logic [15:0] seen;
    logic        all_seen;

    modport master (
        output in_valid, a, b, c, d, clr_seen,
        input  x, y, x_q, y_q, out_valid, seen, all_seen
    );

    modport slave (
        input  in_valid, a, b, c, d, clr_seen,
        output x, y, x_q, y_q, out_valid, seen, all_seen
    );
endinterface

// File: rtl/combi_unit.sv
// Four-input logic cell: x = ab | cd, y = a^b^c^d, with a valid-qualified
// delay chain and a sticky 16-entry input-combination coverage map.
module combi_unit #(
    parameter int PIPE_DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    combi_unit_if.slave  bus
);
    logic [3:0] idx;
    logic       x_comb;
    logic       y_comb;

    assign idx    = {bus.a, bus.b, bus.c, bus.d};
    assign x_comb = (bus.a & bus.b) | (bus.c & bus.d);
    assign y_comb = bus.a ^ bus.b ^ bus.c ^ bus.d;
    assign bus.x  = x_comb;
    assign bus.y  = y_comb;

    logic [PIPE_DEPTH-1:0] v_reg;
    logic [PIPE_DEPTH-1:0] x_reg;
    logic [PIPE_DEPTH-1:0] y_reg;

    // Data bits shift unconditionally; only the valid bit gives them meaning.
    generate
        for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        v_reg[gi] <= 1'b0;
                        x_reg[gi] <= 1'b0;
                        y_reg[gi] <= 1'b0;
                    end else begin
                        v_reg[gi] <= bus.in_valid;
                        x_reg[gi] <= x_comb;
                        y_reg[gi] <= y_comb;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        v_reg[gi] <= 1'b0;
                        x_reg[gi] <= 1'b0;
                        y_reg[gi] <= 1'b0;
                    end else begin
                        v_reg[gi] <= v_reg[gi-1];
                        x_reg[gi] <= x_reg[gi-1];
                        y_reg[gi] <= y_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign bus.out_valid = v_reg[PIPE_DEPTH-1];
    assign bus.x_q       = x_reg[PIPE_DEPTH-1];
    assign bus.y_q       = y_reg[PIPE_DEPTH-1];

    logic [15:0] seen_reg;

    // Clear wins over a same-cycle set, so the concurrent input is dropped.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_seen
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    seen_reg[gi] <= 1'b0;
                end else if (bus.clr_seen) begin
                    seen_reg[gi] <= 1'b0;
                end else if (bus.in_valid && (idx == 4'(gi))) begin
                    seen_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign bus.seen     = seen_reg;
    assign bus.all_seen = &seen_reg;
endmodule

// File: tb/tb_combi_unit.sv
// Scoreboard bench for combi_unit at PIPE_DEPTH 1 and 3 driven in lockstep.
module tb_combi_unit;
    logic clk;
    logic rst_n;

    combi_unit_if bus1();
    combi_unit_if bus3();

    combi_unit #(.PIPE_DEPTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    combi_unit #(.PIPE_DEPTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   due;
        logic x;
        logic y;
    } exp_t;

    exp_t        q [2][$];
    int          dep [2] = '{1, 3};
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [15:0] seen_m;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic model_x(input logic [3:0] i);
        return (int'(i) inside {3, 7, 11, 12, 13, 14, 15});
    endfunction

    function automatic logic model_y(input logic [3:0] i);
        return ($countones(i) % 2) == 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] i, input logic clr, input logic rstn);
        {bus1.a, bus1.b, bus1.c, bus1.d} = i;
        {bus3.a, bus3.b, bus3.c, bus3.d} = i;
        bus1.in_valid = v;
        bus3.in_valid = v;
        bus1.clr_seen = clr;
        bus3.clr_seen = clr;
        rst_n = rstn;
    endtask

    // One clock of stimulus: update model for the coming edge, check outputs after it.
    task automatic step(input logic v, input logic [3:0] i, input logic clr, input logic rstn);
        drive(v, i, clr, rstn);
        if (!rstn) begin
            seen_m = 16'h0000;
            q[0].delete();
            q[1].delete();
        end else begin
            if (clr) seen_m = 16'h0000;
            else if (v) seen_m[i] = 1'b1;
            if (v) begin
                for (int k = 0; k < 2; k++) q[k].push_back('{cyc + dep[k], model_x(i), model_y(i)});
            end
        end
        #1;
        chk("x_d1", {31'd0, bus1.x}, {31'd0, model_x(i)});
        chk("y_d1", {31'd0, bus1.y}, {31'd0, model_y(i)});
        chk("x_d3", {31'd0, bus3.x}, {31'd0, model_x(i)});
        $display("[TB] t=%0t v=%0b idx=%0d clr=%0b rst_n=%0b x=%0b y=%0b", $time, v, i, clr, rstn, bus1.x, bus1.y);
        @(negedge clk);
        chk("seen_d1", {16'd0, bus1.seen}, {16'd0, seen_m});
        chk("seen_d3", {16'd0, bus3.seen}, {16'd0, seen_m});
        chk("all_seen_d1", {31'd0, bus1.all_seen}, {31'd0, &seen_m});
        chk("all_seen_d3", {31'd0, bus3.all_seen}, {31'd0, &seen_m});
        if (!rstn) begin
            chk("rst_out_valid_d1", {31'd0, bus1.out_valid}, 32'd0);
            chk("rst_out_valid_d3", {31'd0, bus3.out_valid}, 32'd0);
            chk("rst_xy_q_d1", {30'd0, bus1.x_q, bus1.y_q}, 32'd0);
            chk("rst_xy_q_d3", {30'd0, bus3.x_q, bus3.y_q}, 32'd0);
        end
    endtask

    // Monitor: pops an expectation whenever a DUT presents out_valid.
    initial begin
        exp_t e;
        logic ov, xq, yq;
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 2; k++) begin
                ov = (k == 0) ? bus1.out_valid : bus3.out_valid;
                xq = (k == 0) ? bus1.x_q : bus3.x_q;
                yq = (k == 0) ? bus1.y_q : bus3.y_q;
                while (q[k].size() > 0 && q[k][0].due < cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL missing_out depth=%0d: got no out_valid expected one at edge %0d", dep[k], q[k][0].due);
                    void'(q[k].pop_front());
                end
                if (ov === 1'b1) begin
                    if (q[k].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_out depth=%0d: got out_valid=1 expected 0 at edge %0d", dep[k], cyc);
                    end else begin
                        e = q[k].pop_front();
                        chk($sformatf("latency_d%0d", dep[k]), cyc, e.due);
                        chk($sformatf("x_q_d%0d", dep[k]), {31'd0, xq}, {31'd0, e.x});
                        chk($sformatf("y_q_d%0d", dep[k]), {31'd0, yq}, {31'd0, e.y});
                    end
                end
            end
        end
    end

    initial begin
        seen_m = 16'h0000;
        step(1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0);

        // Exhaustive combinational sweep, 100 time units per index.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'(i), 1'b0, 1'b1);
            #1;
            chk("sweep_x", {31'd0, bus1.x}, {31'd0, model_x(4'(i))});
            chk("sweep_y", {31'd0, bus1.y}, {31'd0, model_y(4'(i))});
            $display("[TB] sweep idx=%0d x=%0b y=%0b", i, bus1.x, bus1.y);
            #99;
        end

        // Single pulse, then back-to-back 5 and 6.
        step(1'b1, 4'd13, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b0, 1'b1);
        step(1'b1, 4'd5, 1'b0, 1'b1);
        step(1'b1, 4'd6, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b0, 1'b1);

        // Coverage stream, repeat, clear priority.
        step(1'b0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b0, 1'b1);
        chk("all_seen_full", {31'd0, bus1.all_seen}, 32'd1);
        step(1'b1, 4'd4, 1'b0, 1'b1);
        step(1'b1, 4'd9, 1'b1, 1'b1);
        chk("clr_priority", {16'd0, bus3.seen}, 32'h0000);
        step(1'b1, 4'd9, 1'b0, 1'b1);
        chk("seen_after_9", {16'd0, bus3.seen}, 32'h0200);

        // Reset mid-stream flushes in-flight results.
        step(1'b1, 4'd13, 1'b0, 1'b1);
        step(1'b1, 4'd7, 1'b0, 1'b1);
        step(1'b1, 4'd3, 1'b0, 1'b1);
        step(1'b1, 4'd12, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 1'b0, 1'b1);

        // Randomized traffic with occasional clears and resets.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) != 0));
        end
        for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("drain_d1", q[0].size(), 32'd0);
        chk("drain_d3", q[1].size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end
endmodule
